fdl_tune_ctrl: RTL

//  Closed-loop controller driving the 6-bit thermometer select Q of the fine delay line.

---
 rtl/fdl_pkg.sv | 32 +++
 rtl/fdl_pd_filter.sv | 50 +++++
 rtl/fdl_tune_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fdl_pkg.sv
// Shared definitions for the fine-delay-line tuning loop: legal thermometer
// codes, FSM encoding and the one-tap shift helpers.
package fdl_pkg;

  localparam int Q_W = 6;

  // Legal thermometer codes, ordered from maximum to minimum fine delay.
  localparam logic [Q_W-1:0] Q_CODE [7] = '{
    6'b000000, 6'b100000, 6'b110000, 6'b111000,
    6'b111100, 6'b111110, 6'b111111
  };
  localparam logic [Q_W-1:0] Q_MAX_DLY = Q_CODE[0];
  localparam logic [Q_W-1:0] Q_MID     = Q_CODE[3];
  localparam logic [Q_W-1:0] Q_MIN_DLY = Q_CODE[6];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_WAIT_F,
    ST_WAIT_C
  } fsm_state_t;

  // Add delay clears the lowest set bit; remove delay sets the highest clear bit.
  function automatic logic [Q_W-1:0] q_add_delay(input logic [Q_W-1:0] q);
    return {q[Q_W-2:0], 1'b0};
  endfunction

  function automatic logic [Q_W-1:0] q_rem_delay(input logic [Q_W-1:0] q);
    return {1'b1, q[Q_W-1:1]};
  endfunction

endpackage

// File: rtl/fdl_pd_filter.sv
// Up/down integrator for phase-detector decisions; emits a one-cycle step
// request once FILT_LEN agreeing samples accumulate.
module fdl_pd_filter
#(
  parameter int FILT_LEN = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic act,
  input  logic clr,
  input  logic pd_up,
  input  logic pd_dn,
  output logic step_up,
  output logic step_dn
);

  localparam int FW = 5;
  localparam logic signed [FW-1:0] ZERO = 5'sd0;
  localparam logic signed [FW-1:0] ONE  = 5'sd1;
  localparam logic signed [FW-1:0] LIM  = FW'(FILT_LEN);
  localparam logic signed [FW-1:0] NLIM = -LIM;

  logic signed [FW-1:0] fcnt;
  logic signed [FW-1:0] fcnt_nxt;

  // A reversal restarts the count at +/-1 instead of walking back through zero.
  always_comb begin
    fcnt_nxt = fcnt;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    if (act && pd_up && !pd_dn)
      fcnt_nxt = (fcnt < ZERO) ? ONE : fcnt + ONE;
    else if (act && pd_dn && !pd_up)
      fcnt_nxt = (fcnt > ZERO) ? -ONE : fcnt - ONE;
    if (fcnt_nxt == LIM)
      step_up = 1'b1;
    if (fcnt_nxt == NLIM)
      step_dn = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fcnt <= ZERO;
    else if (clr || step_up || step_dn)
      fcnt <= ZERO;
    else
      fcnt <= fcnt_nxt;
  end

endmodule

// File: rtl/fdl_tune_ctrl.sv
// Fine delay line tuning controller: steps the thermometer select one tap per
// filtered PD decision, hands off to the coarse stage at range ends, reports lock.
module fdl_tune_ctrl
  import fdl_pkg::*;
#(
  parameter int FILT_LEN  = 4,
  parameter int STEP_WAIT = 3,
  parameter int CRS_WAIT  = 8,
  parameter int LOCK_CNT  = 6
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           pd_up,
  input  logic           pd_dn,
  input  logic           crs_at_max,
  input  logic           crs_at_min,
  output logic [Q_W-1:0] Q,
  output logic           coarse_inc,
  output logic           coarse_dec,
  output logic           sat,
  output logic           locked
);

  localparam logic [7:0] SW_LOAD = (STEP_WAIT > 0) ? 8'(STEP_WAIT - 1) : 8'd0;
  localparam logic [7:0] CW_LOAD = 8'(CRS_WAIT - 1);
  localparam logic [7:0] LC      = 8'(LOCK_CNT);

  fsm_state_t     state, state_nxt;
  logic [7:0]     timer, timer_nxt;
  logic [Q_W-1:0] q_nxt;
  logic           inc_nxt, dec_nxt, sat_nxt;
  logic           step_up, step_dn, act;
  logic           fine_step, fine_up, lock_clr;
  logic [7:0]     rev_cnt, rev_nxt;
  logic           have_last, last_up;

  assign act = en && (state == ST_TRACK);

  fdl_pd_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk     (clk),
    .rst     (rst),
    .act     (act),
    .clr     (!act),
    .pd_up   (pd_up),
    .pd_dn   (pd_dn),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    q_nxt     = Q;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    sat_nxt   = sat;
    fine_step = 1'b0;
    fine_up   = 1'b0;
    lock_clr  = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      timer_nxt = 8'd0;
      sat_nxt   = 1'b0;
      lock_clr  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_TRACK;
        ST_TRACK: begin
          if (step_up) begin
            if (Q != Q_MAX_DLY) begin
              q_nxt     = q_add_delay(Q);
              fine_step = 1'b1;
              fine_up   = 1'b1;
            end else if (!crs_at_max) begin
              // Wrap to the opposite fine end so total delay stays continuous.
              q_nxt     = Q_MIN_DLY;
              inc_nxt   = 1'b1;
              sat_nxt   = 1'b0;
              lock_clr  = 1'b1;
              state_nxt = ST_WAIT_C;
              timer_nxt = CW_LOAD;
            end else begin
              sat_nxt  = 1'b1;
              lock_clr = 1'b1;
            end
          end else if (step_dn) begin
            if (Q != Q_MIN_DLY) begin
              q_nxt     = q_rem_delay(Q);
              fine_step = 1'b1;
            end else if (!crs_at_min) begin
              q_nxt     = Q_MAX_DLY;
              dec_nxt   = 1'b1;
              sat_nxt   = 1'b0;
              lock_clr  = 1'b1;
              state_nxt = ST_WAIT_C;
              timer_nxt = CW_LOAD;
            end else begin
              sat_nxt  = 1'b1;
              lock_clr = 1'b1;
            end
          end
          if (fine_step) begin
            sat_nxt = 1'b0;
            if (STEP_WAIT > 0) begin
              state_nxt = ST_WAIT_F;
              timer_nxt = SW_LOAD;
            end
          end
        end
        ST_WAIT_F, ST_WAIT_C: begin
          if (timer == 8'd0)
            state_nxt = ST_TRACK;
          else
            timer_nxt = timer - 8'd1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Reversal counting: only a direction change against the previous fine step counts.
  always_comb begin
    rev_nxt = 8'd0;
    if (have_last && (fine_up != last_up))
      rev_nxt = (rev_cnt == LC) ? rev_cnt : rev_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= 8'd0;
      Q          <= Q_MID;
      coarse_inc <= 1'b0;
      coarse_dec <= 1'b0;
      sat        <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      Q          <= q_nxt;
      coarse_inc <= inc_nxt;
      coarse_dec <= dec_nxt;
      sat        <= sat_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rev_cnt   <= 8'd0;
      locked    <= 1'b0;
      have_last <= 1'b0;
      last_up   <= 1'b0;
    end else if (lock_clr) begin
      rev_cnt   <= 8'd0;
      locked    <= 1'b0;
      have_last <= 1'b0;
    end else if (fine_step) begin
      rev_cnt   <= rev_nxt;
      locked    <= (rev_nxt == LC);
      have_last <= 1'b1;
      last_up   <= fine_up;
    end
  end

endmodule
